// File: rtl/hist_eq_mapper.sv
// Histogram-equalisation pixel mapper with a double-buffered 256-entry LUT loaded from an external
// cumulative-histogram SRAM during vertical blanking. Define HISTEQ_STATS_EN to add commit/abort counters.
module hist_eq_mapper #(
  parameter int unsigned HOLDOFF   = 320,
  parameter int unsigned SCALE_MUL = 13978
) (
  input  logic        iPclk,
  input  logic        iRst,
  input  logic        Fval,
  input  logic        Dval,
  input  logic [11:0] Grey,
  output logic [7:0]  oCum_Addr,
  output logic        oCum_Rd,
  input  logic [19:0] iCum_Data,
  output logic [11:0] oGrey_Eq,
  output logic        oDval,
  output logic        oFval,
  output logic        oLut_Ready,
  output logic [1:0]  oState
`ifdef HISTEQ_STATS_EN
  ,
  output logic [15:0] oCommit_Cnt,
  output logic [15:0] oAbort_Cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_LOAD   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d, rd_dly_q, rd_dly_d;
  logic [7:0]    addr_q, addr_d, addr_dly_q, addr_dly_d;
  logic          bank_q, bank_d, ready_q, ready_d;
  logic [11:0]   grey_s1_q, grey_s1_d, lut_s1_q, lut_s1_d, grey_eq_q, grey_eq_d;
  logic          dval_s1_q, dval_s1_d, fval_s1_q, fval_s1_d, ready_s1_q, ready_s1_d;
  logic          dval_o_q, dval_o_d, fval_o_q, fval_o_d;
  logic          fval_rise, fval_fall, abort, commit, wr_en;
  logic [33:0]   prod;
  logic [13:0]   scaled;
  logic [11:0]   entry;

  // NOTE: memories are written in their own reset-free block; the LUT is ignored until oLut_Ready.
  logic [11:0] lut_mem [2][256];

  assign fval_rise = ~fval_s1_q & Fval;
  assign fval_fall = fval_s1_q & ~Fval;

  // Scale the cumulative count to the 12-bit output range, saturating at full scale.
  assign prod   = 34'(iCum_Data) * 34'(SCALE_MUL);
  assign scaled = 14'(prod >> 20);
  assign entry  = (scaled > 14'd4095) ? 12'hFFF : scaled[11:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    rd_dly_d   = rd_q;
    addr_dly_d = addr_q;
    bank_d     = bank_q;
    ready_d    = ready_q;
    abort      = 1'b0;
    commit     = 1'b0;
    wr_en      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fval_fall) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (fval_rise) begin
          abort = 1'b1;
        end else if (cnt_q == CW'(HOLDOFF - 1)) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          rd_d    = 1'b1;
          addr_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (fval_rise) begin
          abort = 1'b1;
        end else begin
          if (rd_q) begin
            rd_d   = (addr_q != 8'hFF);
            addr_d = (addr_q == 8'hFF) ? 8'h00 : addr_q + 8'h01;
          end
          // Read data arrives one cycle after its strobe, tracked by the delayed strobe/address.
          if (rd_dly_q) begin
            wr_en = 1'b1;
            if (addr_dly_q == 8'hFF) state_d = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        // A frame already under way must keep the LUT it started with.
        if (Fval) abort  = 1'b1;
        else      commit = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      rd_d    = 1'b0;
      addr_d  = '0;
    end
    if (commit) begin
      state_d = S_IDLE;
      bank_d  = ~bank_q;
      ready_d = 1'b1;
    end
  end

  // Two-stage pixel pipeline: LUT lookup, then passthrough/LUT select.
  always_comb begin
    grey_s1_d  = Grey;
    dval_s1_d  = Dval;
    fval_s1_d  = Fval;
    ready_s1_d = ready_q;
    lut_s1_d   = lut_mem[bank_q][Grey[11:4]];
    grey_eq_d  = ready_s1_q ? lut_s1_q : grey_s1_q;
    dval_o_d   = dval_s1_q;
    fval_o_d   = fval_s1_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iPclk) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      rd_dly_q   <= 1'b0;
      addr_dly_q <= '0;
      bank_q     <= 1'b0;
      ready_q    <= 1'b0;
      grey_s1_q  <= '0;
      dval_s1_q  <= 1'b0;
      fval_s1_q  <= 1'b0;
      ready_s1_q <= 1'b0;
      lut_s1_q   <= '0;
      grey_eq_q  <= '0;
      dval_o_q   <= 1'b0;
      fval_o_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      rd_dly_q   <= rd_dly_d;
      addr_dly_q <= addr_dly_d;
      bank_q     <= bank_d;
      ready_q    <= ready_d;
      grey_s1_q  <= grey_s1_d;
      dval_s1_q  <= dval_s1_d;
      fval_s1_q  <= fval_s1_d;
      ready_s1_q <= ready_s1_d;
      lut_s1_q   <= lut_s1_d;
      grey_eq_q  <= grey_eq_d;
      dval_o_q   <= dval_o_d;
      fval_o_q   <= fval_o_d;
    end
  end

  always_ff @(posedge iPclk) begin
    if (wr_en) lut_mem[~bank_q][addr_dly_q] <= entry;
  end

  assign oCum_Addr  = addr_q;
  assign oCum_Rd    = rd_q;
  assign oGrey_Eq   = grey_eq_q;
  assign oDval      = dval_o_q;
  assign oFval      = fval_o_q;
  assign oLut_Ready = ready_q;
  assign oState     = state_q;

`ifdef HISTEQ_STATS_EN
  logic [15:0] commit_cnt_q, commit_cnt_d, abort_cnt_q, abort_cnt_d;

  always_comb begin
    commit_cnt_d = commit_cnt_q + 16'(commit);
    abort_cnt_d  = abort_cnt_q + 16'(abort);
  end

  always_ff @(posedge iPclk) begin
    if (iRst) begin
      commit_cnt_q <= '0;
      abort_cnt_q  <= '0;
    end else begin
      commit_cnt_q <= commit_cnt_d;
      abort_cnt_q  <= abort_cnt_d;
    end
  end

  assign oCommit_Cnt = commit_cnt_q;
  assign oAbort_Cnt  = abort_cnt_q;
`endif

endmodule

// File: tb/tb_hist_eq_mapper.sv
// Scoreboard bench for hist_eq_mapper: directed frames, LUT loads from a modelled SRAM, abort and reset cases.
module tb_hist_eq_mapper;

  localparam int HOLDOFF = 320;

  logic        clk = 1'b0;
  logic        iRst, Fval, Dval;
  logic [11:0] Grey;
  logic [7:0]  oCum_Addr;
  logic        oCum_Rd;
  logic [19:0] iCum_Data;
  logic [11:0] oGrey_Eq;
  logic        oDval, oFval, oLut_Ready;
  logic [1:0]  oState;
`ifdef HISTEQ_STATS_EN
  logic [15:0] commit_cnt, abort_cnt;
`endif

  hist_eq_mapper dut (
    .iPclk(clk), .iRst(iRst), .Fval(Fval), .Dval(Dval), .Grey(Grey),
    .oCum_Addr(oCum_Addr), .oCum_Rd(oCum_Rd), .iCum_Data(iCum_Data),
    .oGrey_Eq(oGrey_Eq), .oDval(oDval), .oFval(oFval),
    .oLut_Ready(oLut_Ready), .oState(oState)
`ifdef HISTEQ_STATS_EN
    , .oCommit_Cnt(commit_cnt), .oAbort_Cnt(abort_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] grey;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          rd_run = 0;
  int          last_run = 0;
  int          commits_seen = 0;
  logic [7:0]  rd_exp = 8'h00;
  logic [19:0] cum_tab [256];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: data for the strobed address appears for the following cycle.
  always @(posedge clk) iCum_Data <= oCum_Rd ? cum_tab[oCum_Addr] : 20'h0;

  // Pixel monitor: value, exact 2-cycle latency, and frame alignment.
  always @(negedge clk) begin
    if (!iRst && oDval) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pix_val", oGrey_Eq, e.grey);
        check("pix_lat", cyc - e.cyc, 2);
        check("pix_fval", oFval, 1);
      end
    end
  end

  // Read-strobe monitor: consecutive addresses while reading, address parked at 0 otherwise.
  always @(negedge clk) begin
    if (iRst) begin
      rd_run = 0;
      rd_exp = 8'h00;
    end else if (oCum_Rd) begin
      check("rd_addr", oCum_Addr, rd_exp);
      rd_exp++;
      rd_run++;
    end else begin
      check("addr_idle", oCum_Addr, 0);
      if (rd_run != 0) last_run = rd_run;
      rd_run = 0;
      rd_exp = 8'h00;
    end
    if (!iRst && oState == 2'd3) commits_seen++;
  end

  task automatic start_frame();
    @(posedge clk); #1;
    Fval = 1'b1;
  endtask

  task automatic pixel(input logic [11:0] g, input logic [11:0] e);
    @(posedge clk); #1;
    Grey = g;
    Dval = 1'b1;
    sb_q.push_back('{grey: e, cyc: cyc});
  endtask

  task automatic end_frame(output int fall);
    @(posedge clk); #1;
    Dval = 1'b0;
    @(posedge clk); #1;
    Fval = 1'b0;
    fall = cyc;
  endtask

  // Fall is seen at edge fall+1; reads start HOLDOFF edges later; COMMIT follows the last write.
  task automatic wait_load(input int fall);
    int  first_rd, commit_c, st_wait;
    bit  done;
    first_rd = -1; commit_c = -1; st_wait = -1; done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (cyc == fall + 2) st_wait = oState;
      if (oCum_Rd && first_rd < 0) first_rd = cyc;
      if (commit_c >= 0 && cyc == commit_c + 1) begin
        check("post_state", oState, 0);
        check("post_ready", oLut_Ready, 1);
        done = 1'b1;
      end else if (oState == 2'd3 && commit_c < 0) begin
        commit_c = cyc;
      end
    end
    if (!done) begin
      check("load_timeout", 0, 1);
    end else begin
      check("wait_state", st_wait, 1);
      check("rd_start", first_rd - fall, HOLDOFF + 1);
      check("commit_at", commit_c - fall, HOLDOFF + 256 + 2);
      check("run_len", last_run, 256);
    end
  endtask

  task automatic wait_addr(input logic [7:0] target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (oCum_Rd && oCum_Addr == target) found = 1'b1;
    end
    check("addr_reached", found, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fall;
    for (int i = 0; i < 256; i++) cum_tab[i] = 20'h0;
    cum_tab[8'h80] = 20'd153600;
    cum_tab[8'hFF] = 20'd307200;
    cum_tab[8'h10] = 20'hFFFFF;
    cum_tab[8'h40] = 20'd76800;
    cum_tab[8'h01] = 20'd100;

    // Reset with live-looking inputs so a missing reset shows up.
    iRst = 1'b1; Fval = 1'b1; Dval = 1'b1; Grey = 12'hABC;
    repeat (3) @(posedge clk);
    #1; Fval = 1'b0; Dval = 1'b0;
    @(negedge clk);
    check("rst_grey", oGrey_Eq, 0);
    check("rst_dval", oDval, 0);
    check("rst_fval", oFval, 0);
    check("rst_ready", oLut_Ready, 0);
    check("rst_rd", oCum_Rd, 0);
    check("rst_addr", oCum_Addr, 0);
    check("rst_state", oState, 0);
    iRst = 1'b0;

    // Frame 1: no LUT yet, passthrough.
    start_frame();
    pixel(12'h5A3, 12'h5A3);
    pixel(12'h000, 12'h000);
    pixel(12'hFFF, 12'hFFF);
    pixel(12'h123, 12'h123);
    @(negedge clk);
    check("f1_ready", oLut_Ready, 0);
    end_frame(fall);
    wait_load(fall);

    // Frame 2: LUT built from the first table.
    start_frame();
    pixel(12'h80F, 12'd2047);
    pixel(12'hFF0, 12'd4095);
    pixel(12'h10A, 12'd4095);
    pixel(12'h003, 12'd0);
    pixel(12'h40C, 12'd1023);
    pixel(12'h01F, 12'd1);
    pixel(12'h20A, 12'd0);
    end_frame(fall);

    // Abort: frame restarts while address 100 is being read.
    wait_addr(8'd100);
    Fval = 1'b1;
    @(negedge clk);
    check("abort_state", oState, 0);
    check("abort_rd", oCum_Rd, 0);
    check("abort_ready", oLut_Ready, 1);
`ifdef HISTEQ_STATS_EN
    check("abort_cnt", abort_cnt, 1);
    check("commit_cnt", commit_cnt, 1);
`endif
    pixel(12'h80F, 12'd2047);
    pixel(12'h403, 12'd1023);
    @(negedge clk);
    check("abort_no_commit", commits_seen, 1);

    for (int i = 0; i < 256; i++) cum_tab[i] = 20'h0;
    cum_tab[8'hFF] = 20'd153600;

    // Reset in the middle of a load.
    end_frame(fall);
    wait_addr(8'd50);
    iRst = 1'b1;
    @(negedge clk);
    check("mrst_grey", oGrey_Eq, 0);
    check("mrst_dval", oDval, 0);
    check("mrst_fval", oFval, 0);
    check("mrst_ready", oLut_Ready, 0);
    check("mrst_rd", oCum_Rd, 0);
    check("mrst_addr", oCum_Addr, 0);
    check("mrst_state", oState, 0);
    iRst = 1'b0;

    // Frame 4: passthrough again after reset.
    start_frame();
    pixel(12'h80F, 12'h80F);
    pixel(12'h5A3, 12'h5A3);
    @(negedge clk);
    check("f4_ready", oLut_Ready, 0);
    end_frame(fall);
    wait_load(fall);

    // Frame 5: LUT from the second table.
    start_frame();
    pixel(12'h80F, 12'd0);
    pixel(12'hFF3, 12'd2047);
    @(posedge clk); #1;
    Dval = 1'b0;
    repeat (5) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hist_eq_mapper.md
HIST_EQ_MAPPER -- requirements
Module: hist_eq_mapper

Interface
REQ-001 Parameter HOLDOFF, default 320: cycles waited after Fval falls before cumulative-histogram readout begins.
REQ-002 Parameter SCALE_MUL, default 13978: fixed-point gain, round(4095*2^20/pixels-per-frame), for 307200 pixels.
REQ-003 Port iPclk  input  1: pixel clock; all logic on its rising edge.
REQ-004 Port iRst  input  1: synchronous, active-high reset.
REQ-005 Port Fval  input  1: frame valid, high during active frame.
REQ-006 Port Dval  input  1: pixel valid.
REQ-007 Port Grey  input  12: greyscale pixel; Grey[11:4] is the bin index.
REQ-008 Port oCum_Addr  output  8: cumulative-histogram SRAM read address.
REQ-009 Port oCum_Rd  output  1: read strobe; data is valid exactly 1 cycle later.
REQ-010 Port iCum_Data  input  20: cumulative count for the address presented the previous cycle.
REQ-011 Port oGrey_Eq  output  12: equalised pixel.
REQ-012 Port oDval  output  1: Dval delayed to align with oGrey_Eq.
REQ-013 Port oFval  output  1: Fval delayed to align with oGrey_Eq.
REQ-014 Port oLut_Ready  output  1: high once at least one complete LUT has been committed.
REQ-015 Port oState  output  2: current FSM state (debug).

Function
REQ-016 FSM states SHALL be IDLE=0, WAIT=1, LOAD=2, COMMIT=3.
REQ-017 IDLE->WAIT on a falling edge of Fval (registered Fval 1, current Fval 0); counter cleared.
REQ-018 WAIT SHALL count HOLDOFF cycles, then go to LOAD with address counter 0.
REQ-019 LOAD SHALL assert oCum_Rd with oCum_Addr = 0..255, one per cycle, 256 consecutive cycles.
REQ-020 Each returned iCum_Data SHALL be written 1 cycle after its request into shadow LUT entry at that address.
REQ-021 LUT entry value = min(4095, (iCum_Data * SCALE_MUL) >> 20), using a 34-bit product.
REQ-022 After writing entry 255, COMMIT for 1 cycle: swap shadow/active banks, set oLut_Ready=1, return to IDLE.
REQ-023 Fval rising while in WAIT or LOAD SHALL abort to IDLE; active bank is unchanged, shadow contents are discarded.
REQ-024 Mapping: while oLut_Ready=1, oGrey_Eq = active_LUT[Grey[11:4]]; while 0, oGrey_Eq = Grey (passthrough).
REQ-025 Pixel latency SHALL be exactly 2 cycles for oGrey_Eq, oDval and oFval, in all states.
REQ-026 A bank swap SHALL never occur while Fval=1, so one frame never mixes two LUTs.
REQ-027 oCum_Rd SHALL be 0 outside LOAD; oCum_Addr SHALL hold 0 outside LOAD.

Reset
REQ-028 Reset SHALL force: state IDLE, counters 0, bank select 0, oLut_Ready 0, oCum_Rd 0, oCum_Addr 0.
REQ-029 Reset SHALL also force oGrey_Eq 0, oDval 0, oFval 0 and the delay pipeline cleared.
REQ-030 LUT contents are not reset; they are unused until oLut_Ready=1.
REQ-031 Reset during LOAD SHALL leave no commit; the next commit needs a full new LOAD.

Configuration
REQ-032 Macro HISTEQ_STATS_EN defined: add outputs oCommit_Cnt[15:0] and oAbort_Cnt[15:0].
REQ-033 With HISTEQ_STATS_EN, oCommit_Cnt increments on each COMMIT and oAbort_Cnt on each abort (REQ-023); both wrap at 65535->0 and reset to 0.
REQ-034 Without HISTEQ_STATS_EN, neither port nor counters exist; all other behaviour is identical.

Verification
REQ-035 Reset, then a frame with Grey=0x5A3 and no LUT -> oGrey_Eq=0x5A3 two cycles later; oLut_Ready=0.
REQ-036 Fval falls, then HOLDOFF=320 cycles -> oCum_Rd high for 256 cycles with addresses 0..255; COMMIT at cycle 320+256+1; oLut_Ready=1.
REQ-037 iCum_Data=153600 at bin 0x80, then a frame with Grey=0x80F -> oGrey_Eq=2047; iCum_Data=307200 at bin 0xFF -> 4095.
REQ-038 iCum_Data=0xFFFFF at any bin -> entry saturates to 4095.
REQ-039 Fval rises at LOAD address 100 -> no swap, prior LUT output unchanged, oState=0 (abort counter=1 if HISTEQ_STATS_EN).
REQ-040 iRst asserted mid-LOAD -> all outputs zero next cycle; oLut_Ready=0; passthrough on the next frame.
